// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : CPU/DMA request ports and main-memory port of the memory arbiter.
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 18
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin arbiter sharing single-port main memory
//            between the CPU control path and the DMA/loader port.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 18
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            r_state,     w_nextState;
  logic              r_ownerDma,  w_ownerDma;
  logic              r_lastDma,   w_lastDma;
  logic              r_memEn,     w_memEn;
  logic              r_memWe,     w_memWe;
  logic [ADDR_W-1:0] r_memAddr,   w_memAddr;
  logic [DATA_W-1:0] r_memWdata,  w_memWdata;
  logic              r_cpuGnt,    w_cpuGnt;
  logic              r_dmaGnt,    w_dmaGnt;
  logic              r_cpuRvalid, w_cpuRvalid;
  logic              r_dmaRvalid, w_dmaRvalid;
  logic [DATA_W-1:0] r_cpuRdata,  w_cpuRdata;
  logic [DATA_W-1:0] r_dmaRdata,  w_dmaRdata;
  logic              w_pickDma;

  // DMA wins when alone, or on a tie when the CPU was granted last
  assign w_pickDma = bus.dma_req & (~bus.cpu_req | ~r_lastDma);

  always_comb begin
    w_nextState = r_state;
    w_ownerDma  = r_ownerDma;
    w_lastDma   = r_lastDma;
    w_memEn     = 1'b0;
    w_memWe     = r_memWe;
    w_memAddr   = r_memAddr;
    w_memWdata  = r_memWdata;
    w_cpuGnt    = 1'b0;
    w_dmaGnt    = 1'b0;
    w_cpuRvalid = 1'b0;
    w_dmaRvalid = 1'b0;
    w_cpuRdata  = r_cpuRdata;
    w_dmaRdata  = r_dmaRdata;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          w_ownerDma  = w_pickDma;
          w_lastDma   = w_pickDma;
          w_memEn     = 1'b1;
          w_memWe     = w_pickDma ? bus.dma_we    : bus.cpu_we;
          w_memAddr   = w_pickDma ? bus.dma_addr  : bus.cpu_addr;
          w_memWdata  = w_pickDma ? bus.dma_wdata : bus.cpu_wdata;
          w_dmaGnt    = w_pickDma;
          w_cpuGnt    = ~w_pickDma;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        w_nextState = r_memWe ? IDLE : RESP;
      end
      RESP: begin
        if (r_ownerDma) begin
          w_dmaRdata  = bus.mem_rdata;
          w_dmaRvalid = 1'b1;
        end else begin
          w_cpuRdata  = bus.mem_rdata;
          w_cpuRvalid = 1'b1;
        end
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ownerDma  <= 1'b0;
      r_lastDma   <= 1'b1;
      r_memEn     <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_cpuGnt    <= 1'b0;
      r_dmaGnt    <= 1'b0;
      r_cpuRvalid <= 1'b0;
      r_dmaRvalid <= 1'b0;
      r_cpuRdata  <= '0;
      r_dmaRdata  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_ownerDma  <= w_ownerDma;
      r_lastDma   <= w_lastDma;
      r_memEn     <= w_memEn;
      r_memWe     <= w_memWe;
      r_memAddr   <= w_memAddr;
      r_memWdata  <= w_memWdata;
      r_cpuGnt    <= w_cpuGnt;
      r_dmaGnt    <= w_dmaGnt;
      r_cpuRvalid <= w_cpuRvalid;
      r_dmaRvalid <= w_dmaRvalid;
      r_cpuRdata  <= w_cpuRdata;
      r_dmaRdata  <= w_dmaRdata;
    end
  end

  assign bus.cpu_gnt    = r_cpuGnt;
  assign bus.cpu_rvalid = r_cpuRvalid;
  assign bus.cpu_rdata  = r_cpuRdata;
  assign bus.dma_gnt    = r_dmaGnt;
  assign bus.dma_rvalid = r_dmaRvalid;
  assign bus.dma_rdata  = r_dmaRdata;
  assign bus.mem_en     = r_memEn;
  assign bus.mem_we     = r_memWe;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_wdata  = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 18;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory, plus a back-door preload port
  logic              preEn;
  logic [ADDR_W-1:0] preAddr;
  logic [DATA_W-1:0] preData;
  logic [DATA_W-1:0] memArr [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (preEn) memArr[preAddr] <= preData;
    else if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata        <= memArr[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_cpu_gnt"},    32'(bus.cpu_gnt),    32'h0);
    chk({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'h0);
    chk({tag, "_cpu_rdata"},  32'(bus.cpu_rdata),  32'h0);
    chk({tag, "_dma_gnt"},    32'(bus.dma_gnt),    32'h0);
    chk({tag, "_dma_rvalid"}, 32'(bus.dma_rvalid), 32'h0);
    chk({tag, "_dma_rdata"},  32'(bus.dma_rdata),  32'h0);
    chk({tag, "_mem_en"},     32'(bus.mem_en),     32'h0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     32'h0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'h0);
    chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'h0);
  endtask

  logic [ADDR_W-1:0] sAddr [4];
  logic [DATA_W-1:0] sData [4];

  initial begin
    reset = 1'b1;
    preEn = 1'b0; preAddr = '0; preData = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    sAddr = '{13'h0A5, 13'h010, 13'h020, 13'h0A5};
    sData = '{18'h2ABCD, 18'h00155, 18'h3C3C3, 18'h2ABCD};

    // Reset state, with memory preload under reset
    tick();
    preEn = 1'b1; preAddr = 13'h0A5; preData = 18'h2ABCD;
    tick();
    preEn = 1'b0;
    chkAllZero("reset");
    reset = 1'b0;

    // CPU read of 0x0A5
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0A5;
    tick();
    chk("rd_cpu_gnt",  32'(bus.cpu_gnt),  32'h1);
    chk("rd_mem_en",   32'(bus.mem_en),   32'h1);
    chk("rd_mem_we",   32'(bus.mem_we),   32'h0);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'h0A5);
    chk("rd_dma_gnt",  32'(bus.dma_gnt),  32'h0);
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_resp_mem_en", 32'(bus.mem_en),     32'h0);
    chk("rd_resp_gnt",    32'(bus.cpu_gnt),    32'h0);
    chk("rd_resp_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    tick();
    chk("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    chk("rd_cpu_rdata",  32'(bus.cpu_rdata),  32'h2ABCD);
    chk("rd_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
    chk("rd_dma_rdata",  32'(bus.dma_rdata),  32'h0);
    tick();
    chk("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 32'h0);
    chk("rd_rdata_held",   32'(bus.cpu_rdata),  32'h2ABCD);

    // DMA write 0x010 then CPU read 0x010
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 13'h010; bus.dma_wdata = 18'h00155;
    tick();
    chk("wr_dma_gnt",   32'(bus.dma_gnt),   32'h1);
    chk("wr_mem_en",    32'(bus.mem_en),    32'h1);
    chk("wr_mem_we",    32'(bus.mem_we),    32'h1);
    chk("wr_mem_addr",  32'(bus.mem_addr),  32'h010);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h00155);
    chk("wr_cpu_gnt",   32'(bus.cpu_gnt),   32'h0);
    bus.dma_req = 1'b0;
    tick();
    chk("wr_done_gnt", 32'(bus.dma_gnt), 32'h0);
    chk("wr_done_en",  32'(bus.mem_en),  32'h0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h010;
    tick();
    chk("wr_rd_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    chk("wr_rd_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    chk("wr_rd_rdata",  32'(bus.cpu_rdata),  32'h00155);
    chk("wr_rd_dma_rv", 32'(bus.dma_rvalid), 32'h0);

    // Reset during the RESP cycle of a CPU read
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0A5;
    tick();
    chk("rstrd_gnt", 32'(bus.cpu_gnt), 32'h1);
    bus.cpu_req = 1'b0;
    tick();
    chk("rstrd_resp_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    reset = 1'b1;
    tick();
    chk("rstrd_rvalid0", 32'(bus.cpu_rvalid), 32'h0);
    chk("rstrd_rdata0",  32'(bus.cpu_rdata),  32'h0);
    reset = 1'b0;
    tick();
    chk("rstrd_rvalid1", 32'(bus.cpu_rvalid), 32'h0);
    chk("rstrd_rdata1",  32'(bus.cpu_rdata),  32'h0);
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'h010;
    tick();
    chk("rstrd_next_gnt", 32'(bus.cpu_gnt), 32'h1);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    chk("rstrd_next_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    chk("rstrd_next_rdata",  32'(bus.cpu_rdata),  32'h00155);

    // Two-cycle reset in the ISSUE cycle of a DMA read
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 13'h010;
    tick();
    chk("rstmid_dma_gnt", 32'(bus.dma_gnt), 32'h1);
    bus.dma_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chkAllZero("rstmid");
    reset = 1'b0;
    tick();
    chk("rstmid_no_rvalid", 32'(bus.dma_rvalid), 32'h0);

    // Contention: CPU write 0x020 and DMA read 0x010 both held; CPU wins first
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h020; bus.cpu_wdata = 18'h3C3C3;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 13'h010;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("cont_cpu_gnt_%0d", i), 32'(bus.cpu_gnt),
          (i == 0 || i == 5 || i == 10) ? 32'h1 : 32'h0);
      chk($sformatf("cont_dma_gnt_%0d", i), 32'(bus.dma_gnt),
          (i == 2 || i == 7 || i == 12) ? 32'h1 : 32'h0);
      chk($sformatf("cont_dma_rvalid_%0d", i), 32'(bus.dma_rvalid),
          (i == 4 || i == 9 || i == 14) ? 32'h1 : 32'h0);
      if (i == 4) chk("cont_dma_rdata", 32'(bus.dma_rdata), 32'h00155);
      if (i == 12) begin
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
      end
    end

    // DMA streaming 4 reads with CPU idle
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = sAddr[0];
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("strm_dma_gnt_%0d", i), 32'(bus.dma_gnt),
          (i % 3 == 0 && i <= 9) ? 32'h1 : 32'h0);
      chk($sformatf("strm_dma_rvalid_%0d", i), 32'(bus.dma_rvalid),
          (i % 3 == 2 && i <= 11) ? 32'h1 : 32'h0);
      chk($sformatf("strm_cpu_gnt_%0d", i), 32'(bus.cpu_gnt), 32'h0);
      if (i % 3 == 2 && i <= 11)
        chk($sformatf("strm_dma_rdata_%0d", i / 3), 32'(bus.dma_rdata), 32'(sData[i / 3]));
      if (i % 3 == 0 && i <= 9) begin
        if (i / 3 < 3) bus.dma_addr = sAddr[i / 3 + 1];
        else           bus.dma_req  = 1'b0;
      end
    end
    chk("strm_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
